// File: rtl/vend_dispense_scheduler.sv
// Round-robin scheduler that shares one dispense motor and one change hopper among N_REQ panels.
// Define VEND_AUDIT_EN to add the audit_vends / audit_jams counters.
module vend_dispense_scheduler #(
    parameter int N_REQ       = 4,
    parameter int STOCK_MAX   = 15,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [2*N_REQ-1:0] req_item,
    input  logic [2*N_REQ-1:0] req_change,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   req_nak,
    output logic               motor_start,
    output logic [1:0]         motor_item,
    input  logic               motor_done,
    output logic               coin_out,
    output logic               busy,
    output logic               fault,
    input  logic               fault_clr,
    input  logic               restock,
    input  logic [1:0]         restock_item,
    output logic [2:0]         sold_out
`ifdef VEND_AUDIT_EN
    ,
    output logic [15:0]        audit_vends,
    output logic [7:0]         audit_jams
`endif
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, MOTOR, CHANGE, GAP, ACK} state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, rr_ptr, rr_d, rr_next, gnt_idx;
    logic             gnt_found;
    logic [N_REQ-1:0] req_eff;
    logic [1:0]       item_d, chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       stock_q [3];
    logic [3:0]       stock_d [3];
    logic [3:0]       cur_stock;
    logic             fault_d, start_d, coin_d, dec, jam;
    logic [N_REQ-1:0] ack_d, nak_d;
    logic [2:0]       sold_d;
    int unsigned      pos;

    // A panel whose ack/nak pulses this cycle has not seen it yet, so its valid is still high.
    assign req_eff = req_valid & ~(req_ack | req_nak);
    assign rr_next = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(rr_ptr) + k) % 32'(N_REQ);
            if (!gnt_found && req_eff[IDX_W'(pos)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(pos);
            end
        end
    end

    always_comb begin
        case (motor_item)
            2'd1:    cur_stock = stock_q[0];
            2'd2:    cur_stock = stock_q[1];
            2'd3:    cur_stock = stock_q[2];
            default: cur_stock = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        item_d  = motor_item;
        chg_d   = chg_q;
        cnt_d   = cnt_q;
        rr_d    = rr_ptr;
        fault_d = fault & ~fault_clr;
        ack_d   = '0;
        nak_d   = '0;
        start_d = 1'b0;
        dec     = 1'b0;
        jam     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    idx_d   = gnt_idx;
                    item_d  = req_item[{gnt_idx, 1'b0} +: 2];
                    chg_d   = req_change[{gnt_idx, 1'b0} +: 2];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Item 00 reads as zero stock, so it is refused by the same test.
                if (fault || cur_stock == '0) begin
                    nak_d[idx_q] = 1'b1;
                    rr_d         = rr_next;
                    state_d      = IDLE;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = MOTOR;
                end
            end
            MOTOR: begin
                if (motor_done) begin
                    dec     = 1'b1;
                    state_d = (chg_q != '0) ? CHANGE : ACK;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    jam          = 1'b1;
                    fault_d      = 1'b1;
                    nak_d[idx_q] = 1'b1;
                    rr_d         = rr_next;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHANGE: begin
                chg_d   = chg_q - 1'b1;
                state_d = GAP;
            end
            GAP: begin
                state_d = (chg_q != '0) ? CHANGE : ACK;
            end
            ACK: begin
                ack_d[idx_q] = 1'b1;
                rr_d         = rr_next;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        coin_d = (state_d == CHANGE);
    end

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            stock_d[k] = stock_q[k];
            if (dec && motor_item == 2'(k + 1))
                stock_d[k] = stock_q[k] - 4'd1;
            if (restock && restock_item == 2'(k + 1))
                stock_d[k] = 4'(STOCK_MAX);
            sold_d[k] = (stock_d[k] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            rr_ptr      <= '0;
            motor_item  <= '0;
            chg_q       <= '0;
            cnt_q       <= '0;
            fault       <= 1'b0;
            req_ack     <= '0;
            req_nak     <= '0;
            motor_start <= 1'b0;
            coin_out    <= 1'b0;
            busy        <= 1'b0;
            sold_out    <= '0;
            for (int unsigned k = 0; k < 3; k++)
                stock_q[k] <= 4'(STOCK_MAX);
        end else begin
            idx_q       <= idx_d;
            rr_ptr      <= rr_d;
            motor_item  <= item_d;
            chg_q       <= chg_d;
            cnt_q       <= cnt_d;
            fault       <= fault_d;
            req_ack     <= ack_d;
            req_nak     <= nak_d;
            motor_start <= start_d;
            coin_out    <= coin_d;
            busy        <= (state_d != IDLE);
            sold_out    <= sold_d;
            stock_q     <= stock_d;
        end
    end

`ifdef VEND_AUDIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audit_vends <= '0;
            audit_jams  <= '0;
        end else begin
            if (state_d == ACK && audit_vends != '1)
                audit_vends <= audit_vends + 1'b1;
            if (jam && audit_jams != '1)
                audit_jams <= audit_jams + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Directed self-checking bench for vend_dispense_scheduler (TIMEOUT_CYC shortened to 20).
module tb_vend_dispense_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_item;
    logic [2*N-1:0] req_change;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   req_nak;
    logic           motor_start;
    logic [1:0]     motor_item;
    logic           motor_done;
    logic           coin_out;
    logic           busy;
    logic           fault;
    logic           fault_clr;
    logic           restock;
    logic [1:0]     restock_item;
    logic [2:0]     sold_out;
`ifdef VEND_AUDIT_EN
    logic [15:0]    audit_vends;
    logic [7:0]     audit_jams;
`endif

    int          checks = 0;
    int          errors = 0;
    int          starts, coins, coin_adj, acks, naks, start_n, res_n, last_item;
    int          total_acks, total_starts;
    logic [31:0] ord_sig;

    always #5 clk = ~clk;

    vend_dispense_scheduler #(
        .N_REQ(4),
        .STOCK_MAX(15),
        .TIMEOUT_CYC(20),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_item(req_item),
        .req_change(req_change),
        .req_ack(req_ack),
        .req_nak(req_nak),
        .motor_start(motor_start),
        .motor_item(motor_item),
        .motor_done(motor_done),
        .coin_out(coin_out),
        .busy(busy),
        .fault(fault),
        .fault_clr(fault_clr),
        .restock(restock),
        .restock_item(restock_item),
        .sold_out(sold_out)
`ifdef VEND_AUDIT_EN
        ,
        .audit_vends(audit_vends),
        .audit_jams(audit_jams)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int p, input logic [1:0] it, input logic [1:0] ch);
        req_valid[p]         = 1'b1;
        req_item[2*p +: 2]   = it;
        req_change[2*p +: 2] = ch;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_valid    = '0;
        motor_done   = 1'b0;
        fault_clr    = 1'b0;
        restock      = 1'b0;
        restock_item = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Plays panels and motor until every request is answered; panels drop valid on their ack/nak.
    task automatic run(input int budget, input int done_delay, input bit drop_at_start,
                       input logic [N-1:0] inj_mask);
        int n = 0;
        int dcnt = -1;
        bit prev_coin = 1'b0;
        bit injected = 1'b0;
        starts = 0; coins = 0; coin_adj = 0; acks = 0; naks = 0;
        start_n = 0; res_n = 0; last_item = 0; ord_sig = '0;
        while ((req_valid != '0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
            motor_done = 1'b0;
            if (motor_start) begin
                starts++;
                start_n   = n;
                last_item = int'(motor_item);
                if (done_delay >= 0) dcnt = done_delay;
                if (drop_at_start) req_valid = '0;
            end
            if (dcnt == 0) begin
                motor_done = 1'b1;
                dcnt = -1;
            end else if (dcnt > 0) begin
                dcnt--;
            end
            if (coin_out) begin
                coins++;
                if (prev_coin) coin_adj++;
            end
            prev_coin = coin_out;
            for (int p = 0; p < N; p++) begin
                if (req_ack[p] || req_nak[p]) begin
                    if (req_ack[p]) acks++;
                    else            naks++;
                    ord_sig      = (ord_sig << 4) | 32'(p + 1);
                    res_n        = n;
                    req_valid[p] = 1'b0;
                    if (!injected && inj_mask != '0) begin
                        req_valid = req_valid | inj_mask;
                        injected  = 1'b1;
                    end
                end
            end
        end
        motor_done = 1'b0;
        chk("run_budget_expired", 32'(n >= budget), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        req_item   = '0;
        req_change = '0;
        do_reset();

        // Reset state
        chk("rst_ack", req_ack, 0);
        chk("rst_nak", req_nak, 0);
        chk("rst_ctl", {motor_start, coin_out, busy, fault}, 0);
        chk("rst_motor_item", motor_item, 0);
        chk("rst_sold_out", sold_out, 0);

        // Single vend: panel 0, item 01, change 2
        post(0, 2'd1, 2'd2);
        run(100, 0, 1'b0, '0);
        chk("v1_starts", starts, 1);
        chk("v1_item", last_item, 1);
        chk("v1_start_lat", start_n, 2);
        chk("v1_coins", coins, 2);
        chk("v1_coin_adjacent", coin_adj, 0);
        chk("v1_acks", acks, 1);
        chk("v1_naks", naks, 0);
        chk("v1_order", ord_sig, 32'h1);
        chk("v1_ack_cycle", res_n, 8);
        chk("v1_stock1", dut.stock_q[0], 14);

        // Panel drops valid once the motor starts; transaction still completes
        post(2, 2'd1, 2'd1);
        run(100, 1, 1'b1, '0);
        chk("drop_acks", acks, 1);
        chk("drop_coins", coins, 1);
        chk("drop_order", ord_sig, 32'h3);
        chk("drop_stock1", dut.stock_q[0], 13);

        // Round robin: 1 and 3 from rr_ptr=0; 0 and 1 post once 1 is acked (rr_ptr=2)
        do_reset();
        req_item[1:0]   = 2'd2;
        req_change[1:0] = 2'd0;
        post(1, 2'd2, 2'd0);
        post(3, 2'd2, 2'd0);
        run(200, 0, 1'b0, 4'b0011);
        chk("rr_order", ord_sig, 32'h2412);
        chk("rr_acks", acks, 4);
        chk("rr_starts", starts, 4);

        // Invalid item 00 is refused in CHECK
        post(3, 2'd0, 2'd1);
        run(50, 0, 1'b0, '0);
        chk("inv_naks", naks, 1);
        chk("inv_starts", starts, 0);
        chk("inv_nak_cycle", res_n, 2);
        chk("inv_order", ord_sig, 32'h4);

        // Sold out on item 11, then restock
        do_reset();
        total_acks   = 0;
        total_starts = 0;
        for (int i = 0; i < 15; i++) begin
            post(2, 2'd3, 2'd0);
            run(100, 0, 1'b0, '0);
            total_acks   += acks;
            total_starts += starts;
        end
        chk("so_total_acks", total_acks, 15);
        chk("so_total_starts", total_starts, 15);
        chk("so_sold_out", sold_out, 3'b100);
        post(2, 2'd3, 2'd0);
        run(100, 0, 1'b0, '0);
        chk("so16_naks", naks, 1);
        chk("so16_starts", starts, 0);
        @(negedge clk);
        restock      = 1'b1;
        restock_item = 2'd3;
        @(negedge clk);
        restock      = 1'b0;
        restock_item = 2'd0;
        chk("so_restocked", sold_out, 3'b000);
        post(2, 2'd3, 2'd0);
        run(100, 0, 1'b0, '0);
        chk("so_after_restock_acks", acks, 1);
        chk("so_after_restock_item", last_item, 3);

        // Jam: motor_done never arrives
        do_reset();
        post(0, 2'd1, 2'd1);
        run(60, -1, 1'b0, '0);
        chk("jam_naks", naks, 1);
        chk("jam_starts", starts, 1);
        chk("jam_timeout_cycles", res_n - start_n, 20);
        chk("jam_fault", fault, 1);
        chk("jam_coins", coins, 0);
        chk("jam_stock1", dut.stock_q[0], 15);
        post(1, 2'd2, 2'd0);
        run(60, 0, 1'b0, '0);
        chk("jam_locked_naks", naks, 1);
        chk("jam_locked_starts", starts, 0);
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("jam_fault_cleared", fault, 0);
        post(1, 2'd2, 2'd0);
        run(100, 3, 1'b0, '0);
        chk("jam_recover_acks", acks, 1);
        chk("jam_recover_starts", starts, 1);
        post(0, 2'd1, 2'd0);
        run(100, 0, 1'b0, '0);
        post(2, 2'd3, 2'd1);
        run(100, 0, 1'b0, '0);
        chk("jam_last_acks", acks, 1);
`ifdef VEND_AUDIT_EN
        chk("audit_vends", audit_vends, 3);
        chk("audit_jams", audit_jams, 1);
`endif

        // Asynchronous reset during CHANGE
        post(0, 2'd1, 2'd3);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            motor_done = motor_start;
            if (coin_out) seen = 1'b1;
        end
        chk("arst_reached_change", seen, 1);
        rst = 1'b1;
        #1;
        chk("arst_coin_out", coin_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_stock", {dut.stock_q[0], dut.stock_q[1], dut.stock_q[2]}, 12'hFFF);
        motor_done = 1'b0;
        req_valid  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_no_resp", {req_ack, req_nak, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
